commit_tracker: RTL

Retirement-record generator on the pipeline side of the trace interface. It follows every instruction from issue through X, M and retire, assigns it a monotonically increasing sequence ID, and holds its PC, instruction word, writeback and redirect results in a small in-order buffer. It then drives the registered, cycle-aligned commit stream and Konata stage pulses consumed by the trace logger. It sits between the core's stage-advance strobes and the trace logger's input ports.

---
 rtl/commit_tracker_pkg.sv | 28 ++
 rtl/commit_tracker_if.sv | 55 +++++
 rtl/commit_fifo.sv | 56 +++++
 rtl/commit_tracker.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/commit_tracker_pkg.sv
// Shared types for the commit tracker: buffer entry layout, sequence width
// and the pipeline stage names used when inspecting in-flight entries.
package commit_tracker_pkg;

    localparam int SEQ_W = 32;

    typedef enum logic [1:0] {
        STG_I,
        STG_X,
        STG_M
    } stage_t;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             wbv;
        logic [4:0]       rd;
        logic [31:0]      data;
        logic             brv;
        logic [31:0]      target;
    } entry_t;

    function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] s);
        return s + SEQ_W'(1);
    endfunction

endpackage

// File: rtl/commit_tracker_if.sv
// Stage-advance strobes from the core and the registered commit/Konata
// stream towards the trace logger, bundled as one interface.
interface commit_tracker_if;
    import commit_tracker_pkg::*;

    logic             issue_v;
    logic [31:0]      issue_pc;
    logic [31:0]      issue_inst;
    logic             issue_ready;
    logic             x_v;
    logic             wb_v;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             br_v;
    logic [31:0]      br_target;
    logic             flush_v;
    logic             m_v;
    logic             r_v;

    logic             valid;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             rdv;
    logic [4:0]       rd_x;
    logic [31:0]      rd_data;
    logic             pcv;
    logic [31:0]      pc_x;
    logic             inst_v_i;
    logic             inst_v_x;
    logic             inst_v_m;
    logic             inst_v_r;
    logic [SEQ_W-1:0] ci;
    logic [SEQ_W-1:0] cx;
    logic [SEQ_W-1:0] cm;
    logic [SEQ_W-1:0] cr;
    logic [2:0]       flushed;
    logic             proto_err;

    modport master (
        output issue_v, issue_pc, issue_inst, x_v, wb_v, wb_rd, wb_data,
               br_v, br_target, flush_v, m_v, r_v,
        input  issue_ready, valid, pc, inst, rdv, rd_x, rd_data, pcv, pc_x,
               inst_v_i, inst_v_x, inst_v_m, inst_v_r, ci, cx, cm, cr,
               flushed, proto_err
    );

    modport slave (
        input  issue_v, issue_pc, issue_inst, x_v, wb_v, wb_rd, wb_data,
               br_v, br_target, flush_v, m_v, r_v,
        output issue_ready, valid, pc, inst, rdv, rd_x, rd_data, pcv, pc_x,
               inst_v_i, inst_v_x, inst_v_m, inst_v_r, ci, cx, cm, cr,
               flushed, proto_err
    );

endinterface

// File: rtl/commit_fifo.sv
// Entry storage for the commit tracker: whole-entry write at the tail slot,
// writeback/redirect update of the X slot, and three indexed read ports.
module commit_fifo
    import commit_tracker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_idx,
    input  entry_t           wr_data,
    input  logic             upd_en,
    input  logic [AW-1:0]    upd_idx,
    input  logic             upd_wbv,
    input  logic [4:0]       upd_rd,
    input  logic [31:0]      upd_data,
    input  logic             upd_brv,
    input  logic [31:0]      upd_target,
    input  logic [AW-1:0]    rd_idx_x,
    input  logic [AW-1:0]    rd_idx_m,
    input  logic [AW-1:0]    rd_idx_r,
    output logic [SEQ_W-1:0] seq_x,
    output logic [SEQ_W-1:0] seq_m,
    output entry_t           ent_r
);

    entry_t ent [DEPTH];

    // Tail and X slots are always distinct when both are enabled, so the
    // write takes priority only as a tie-break that never actually occurs.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            entry_t ent_reg;

            always_ff @(posedge clk) begin
                if (wr_en && wr_idx == AW'(gi)) begin
                    ent_reg <= wr_data;
                end else if (upd_en && upd_idx == AW'(gi)) begin
                    ent_reg.wbv    <= upd_wbv;
                    ent_reg.rd     <= upd_rd;
                    ent_reg.data   <= upd_data;
                    ent_reg.brv    <= upd_brv;
                    ent_reg.target <= upd_target;
                end
            end

            assign ent[gi] = ent_reg;
        end
    endgenerate

    assign seq_x = ent[rd_idx_x].seq;
    assign seq_m = ent[rd_idx_m].seq;
    assign ent_r = ent[rd_idx_r];

endmodule

// File: rtl/commit_tracker.sv
// Follows each instruction from issue to retire in an in-order buffer and
// emits registered Konata stage pulses plus the retire record stream.
module commit_tracker
    import commit_tracker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    commit_tracker_if.slave bus
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            PW      = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]    head_reg, xp_reg, mp_reg, tail_reg;
    logic [PW-1:0]    head_next, xp_next, mp_next, tail_next;
    logic [SEQ_W-1:0] seq_ctr_reg, seq_ctr_next;
    logic [PW-1:0]    i_cnt, x_cnt, m_cnt, total;
    logic             full, ready;
    logic             issue_ok, x_ok, flush_ok, m_ok, r_ok, viol;
    logic [2:0]       flushed_next;
    entry_t           new_ent, ent_r;
    logic [SEQ_W-1:0] seq_x, seq_m;

    logic             valid_reg, rdv_reg, pcv_reg;
    logic [31:0]      pc_reg, inst_reg, rd_data_reg, pc_x_reg;
    logic [4:0]       rd_x_reg;
    logic             inst_v_i_reg, inst_v_x_reg, inst_v_m_reg, inst_v_r_reg;
    logic [SEQ_W-1:0] ci_reg, cx_reg, cm_reg, cr_reg;
    logic [2:0]       flushed_reg;
    logic             proto_err_reg;

    assign i_cnt = tail_reg - xp_reg;
    assign x_cnt = xp_reg - mp_reg;
    assign m_cnt = mp_reg - head_reg;
    assign total = tail_reg - head_reg;
    assign full  = (total == DEPTH_P);
    assign ready = !full && !bus.flush_v;

    // Availability is judged on registered counts only: an entry that moves
    // into a stage this cycle cannot also leave it this cycle.
    assign issue_ok = bus.issue_v && ready;
    assign x_ok     = bus.x_v && (i_cnt != '0);
    assign flush_ok = bus.flush_v && x_ok;
    assign m_ok     = bus.m_v && (x_cnt != '0);
    assign r_ok     = bus.r_v && (m_cnt != '0);
    assign viol     = (bus.x_v && (i_cnt == '0)) ||
                      (bus.m_v && (x_cnt == '0)) ||
                      (bus.r_v && (m_cnt == '0)) ||
                      (bus.flush_v && !bus.x_v) ||
                      (bus.issue_v && !ready);

    always_comb begin
        new_ent        = '0;
        new_ent.seq    = seq_ctr_reg;
        new_ent.pc     = bus.issue_pc;
        new_ent.inst   = bus.issue_inst;

        head_next      = r_ok ? head_reg + ONE_P : head_reg;
        mp_next        = m_ok ? mp_reg + ONE_P : mp_reg;
        xp_next        = x_ok ? xp_reg + ONE_P : xp_reg;
        tail_next      = issue_ok ? tail_reg + ONE_P : tail_reg;
        seq_ctr_next   = issue_ok ? seq_inc(seq_ctr_reg) : seq_ctr_reg;
        flushed_next   = 3'd0;

        // Everything behind the flushing X entry is dropped; the sequence
        // counter is left alone so discarded IDs are never reused.
        if (flush_ok) begin
            tail_next    = xp_reg + ONE_P;
            flushed_next = 3'(i_cnt - ONE_P);
        end
    end

    commit_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .wr_en      (issue_ok),
        .wr_idx     (tail_reg[AW-1:0]),
        .wr_data    (new_ent),
        .upd_en     (x_ok),
        .upd_idx    (xp_reg[AW-1:0]),
        .upd_wbv    (bus.wb_v && (bus.wb_rd != 5'd0)),
        .upd_rd     (bus.wb_rd),
        .upd_data   (bus.wb_data),
        .upd_brv    (bus.br_v),
        .upd_target (bus.br_target),
        .rd_idx_x   (xp_reg[AW-1:0]),
        .rd_idx_m   (mp_reg[AW-1:0]),
        .rd_idx_r   (head_reg[AW-1:0]),
        .seq_x      (seq_x),
        .seq_m      (seq_m),
        .ent_r      (ent_r)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_reg      <= '0;
            xp_reg        <= '0;
            mp_reg        <= '0;
            tail_reg      <= '0;
            seq_ctr_reg   <= '0;
            valid_reg     <= 1'b0;
            rdv_reg       <= 1'b0;
            pcv_reg       <= 1'b0;
            pc_reg        <= '0;
            inst_reg      <= '0;
            rd_x_reg      <= '0;
            rd_data_reg   <= '0;
            pc_x_reg      <= '0;
            inst_v_i_reg  <= 1'b0;
            inst_v_x_reg  <= 1'b0;
            inst_v_m_reg  <= 1'b0;
            inst_v_r_reg  <= 1'b0;
            ci_reg        <= '0;
            cx_reg        <= '0;
            cm_reg        <= '0;
            cr_reg        <= '0;
            flushed_reg   <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            head_reg      <= head_next;
            xp_reg        <= xp_next;
            mp_reg        <= mp_next;
            tail_reg      <= tail_next;
            seq_ctr_reg   <= seq_ctr_next;

            valid_reg     <= r_ok;
            rdv_reg       <= r_ok && ent_r.wbv;
            pcv_reg       <= r_ok && ent_r.brv;
            inst_v_i_reg  <= issue_ok;
            inst_v_x_reg  <= x_ok;
            inst_v_m_reg  <= m_ok;
            inst_v_r_reg  <= r_ok;
            flushed_reg   <= flushed_next;
            proto_err_reg <= proto_err_reg | viol;

            if (issue_ok) begin
                ci_reg <= seq_ctr_reg;
            end
            if (x_ok) begin
                cx_reg <= seq_x;
            end
            if (m_ok) begin
                cm_reg <= seq_m;
            end
            if (r_ok) begin
                cr_reg      <= ent_r.seq;
                pc_reg      <= ent_r.pc;
                inst_reg    <= ent_r.inst;
                rd_x_reg    <= ent_r.rd;
                rd_data_reg <= ent_r.data;
                pc_x_reg    <= ent_r.target;
            end
        end
    end

    assign bus.issue_ready = ready;
    assign bus.valid       = valid_reg;
    assign bus.pc          = pc_reg;
    assign bus.inst        = inst_reg;
    assign bus.rdv         = rdv_reg;
    assign bus.rd_x        = rd_x_reg;
    assign bus.rd_data     = rd_data_reg;
    assign bus.pcv         = pcv_reg;
    assign bus.pc_x        = pc_x_reg;
    assign bus.inst_v_i    = inst_v_i_reg;
    assign bus.inst_v_x    = inst_v_x_reg;
    assign bus.inst_v_m    = inst_v_m_reg;
    assign bus.inst_v_r    = inst_v_r_reg;
    assign bus.ci          = ci_reg;
    assign bus.cx          = cx_reg;
    assign bus.cm          = cm_reg;
    assign bus.cr          = cr_reg;
    assign bus.flushed     = flushed_reg;
    assign bus.proto_err   = proto_err_reg;

endmodule
